// File: rtl/uart_alu_interface.sv
//------------------------------------------------------------------------------
// Module : uart_alu_interface
// Brief  : Collects A/B/opcode bytes from the UART receiver, drives the ALU
//          operand registers and forwards the ALU result to the transmitter.
//          Optional inter-byte timeout enabled by macro UART_IF_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_alu_interface #(
  parameter int DBIT        = 8,
  parameter int OPW         = 6,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] a_out,
  output logic [DBIT-1:0] b_out,
  output logic [OPW-1:0]  op_out,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            busy,
  output logic            overrun,
  output logic            frame_err
);

  localparam logic [5:0] S_GET_A   = 6'b000001;
  localparam logic [5:0] S_GET_B   = 6'b000010;
  localparam logic [5:0] S_GET_OP  = 6'b000100;
  localparam logic [5:0] S_EXEC    = 6'b001000;
  localparam logic [5:0] S_SEND    = 6'b010000;
  localparam logic [5:0] S_WAIT_TX = 6'b100000;

  logic [5:0]      state_q, state_d;
  logic [DBIT-1:0] a_q, a_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_hit;

`ifdef UART_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counts only while parked in a collecting state; any transition clears it.
  always_comb begin
    cnt_d = '0;
    if (((state_q == S_GET_B) || (state_q == S_GET_OP)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_GET_A: begin
        if (rx_done_tick) begin
          a_d     = rx_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (rx_done_tick) begin
          b_d     = rx_data;
          state_d = S_GET_OP;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = S_GET_A;
        end
      end
      S_GET_OP: begin
        if (rx_done_tick) begin
          op_d    = rx_data[OPW-1:0];
          state_d = S_EXEC;
        end else if (timeout_hit) begin
          frame_err_d = 1'b1;
          state_d     = S_GET_A;
        end
      end
      S_EXEC: begin
        overrun_d = rx_done_tick;
        state_d   = S_SEND;
      end
      S_SEND: begin
        overrun_d  = rx_done_tick;
        tx_data_d  = alu_result;
        tx_start_d = 1'b1;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        overrun_d = rx_done_tick;
        if (tx_done_tick) begin
          state_d = S_GET_A;
        end
      end
      default: begin
        state_d = S_GET_A;
      end
    endcase

    // Registered from the next state so busy lines up with the state register.
    busy_d = (state_d == S_EXEC) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
  end

  // Output mapping
  always_comb begin
    a_out     = a_q;
    b_out     = b_q;
    op_out    = op_q;
    tx_data   = tx_data_q;
    tx_start  = tx_start_q;
    busy      = busy_q;
    overrun   = overrun_q;
    frame_err = frame_err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
//------------------------------------------------------------------------------
// Module : tb_uart_alu_interface
// Brief  : Self-checking bench for uart_alu_interface (table-driven commands
//          plus directed overrun, reset and idle-period sequences).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_alu_interface;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done_tick;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic [5:0] op_out;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int tx_cnt = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } cmd_t;

  cmd_t vec [5];

  uart_alu_interface #(
    .DBIT        (8),
    .OPW         (6),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .a_out        (a_out),
    .b_out        (b_out),
    .op_out       (op_out),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  // Stand-in ALU: an adder on the operand registers
  assign alu_result = a_out + b_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start)  tx_cnt   <= tx_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (actual=running, required=finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
  endtask

  task automatic run_cmd(input cmd_t c);
    int tx0;
    int ov0;
    tx0 = tx_cnt;
    ov0 = ovr_cnt;
    send_byte(c.a);
    send_byte(c.b);
    send_byte(c.op);
    check("a_out", a_out, c.a);
    check("b_out", b_out, c.b);
    check("op_out", op_out, c.exp_op);
    check("busy_exec", busy, 1);
    check("tx_start_exec", tx_start, 0);
    step();
    check("tx_start_send", tx_start, 0);
    step();
    check("tx_start_pulse", tx_start, 1);
    check("tx_data", tx_data, c.exp_res);
    step();
    check("tx_start_width", tx_start, 0);
    check("busy_wait", busy, 1);
    repeat (8) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("busy_done", busy, 0);
    step();
    check("tx_pulses", tx_cnt - tx0, 1);
    check("no_overrun", ovr_cnt - ov0, 0);
  endtask

  initial begin
    vec[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp_op: 6'h20, exp_res: 8'h08};
    vec[1] = '{a: 8'h10, b: 8'hF0, op: 8'hE2, exp_op: 6'h22, exp_res: 8'h00};
    vec[2] = '{a: 8'hFF, b: 8'h01, op: 8'h3F, exp_op: 6'h3F, exp_res: 8'h00};
    vec[3] = '{a: 8'h7F, b: 8'h7F, op: 8'hC1, exp_op: 6'h01, exp_res: 8'hFE};
    vec[4] = '{a: 8'h01, b: 8'h02, op: 8'h00, exp_op: 6'h00, exp_res: 8'h03};

    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    repeat (3) step();
    check("rst_a", a_out, 0);
    check("rst_b", b_out, 0);
    check("rst_op", op_out, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_flags", {tx_start, busy, overrun, frame_err}, 0);
    reset = 1'b1;
    step();

    // Back-to-back table commands
    for (int i = 0; i < 4; i++) begin
      run_cmd(vec[i]);
    end

    // tx_done_tick while idle changes nothing
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("idle_txdone_busy", busy, 0);
    check("idle_txdone_a", a_out, 8'h7F);

    // Overrun: byte arrives during WAIT_TX
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    repeat (3) step();
    check("ovr_pre_busy", busy, 1);
    send_byte(8'hAA);
    check("ovr_pulse", overrun, 1);
    check("ovr_keep_a", a_out, 8'h05);
    check("ovr_keep_b", b_out, 8'h03);
    check("ovr_keep_op", op_out, 6'h20);
    check("ovr_keep_tx", tx_data, 8'h08);
    step();
    check("ovr_width", overrun, 0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("ovr_release", busy, 0);
    run_cmd(vec[1]);

    // Simultaneous rx and tx done ticks in WAIT_TX
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h01);
    repeat (3) step();
    rx_data      = 8'h99;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    step();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    check("sim_busy", busy, 0);
    check("sim_overrun", overrun, 1);
    check("sim_keep_a", a_out, 8'h40);
    step();
    check("sim_overrun_width", overrun, 0);
    run_cmd(vec[2]);

    // Asynchronous reset mid-command discards stale bytes
    send_byte(8'h33);
    send_byte(8'h44);
    #2;
    reset = 1'b0;
    #1;
    check("arst_a", a_out, 0);
    check("arst_b", b_out, 0);
    check("arst_op", op_out, 0);
    check("arst_tx_data", tx_data, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    run_cmd(vec[4]);

    // Long idle after the first byte
    begin
      int f0;
      f0 = ferr_cnt;
      send_byte(8'h11);
      repeat (100) step();
`ifdef UART_IF_TIMEOUT_EN
      repeat (2) step();
      check("timeout_ferr", ferr_cnt - f0, 1);
      check("timeout_a_kept", a_out, 8'h11);
      run_cmd('{a: 8'h21, b: 8'h12, op: 8'h47, exp_op: 6'h07, exp_res: 8'h33});
`else
      check("idle_no_ferr", ferr_cnt - f0, 0);
      check("idle_busy", busy, 0);
      send_byte(8'h22);
      send_byte(8'h05);
      check("idle_resume_a", a_out, 8'h11);
      check("idle_resume_b", b_out, 8'h22);
      check("idle_resume_op", op_out, 6'h05);
      repeat (2) step();
      check("idle_resume_tx", tx_data, 8'h33);
      check("idle_resume_start", tx_start, 1);
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      check("idle_frame_err", frame_err, 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
Downstream consumer of the UART receiver's dout/rx_done_tick. Collects a three-byte command (operand A, operand B, opcode) from the receiver and drives the ALU operand/opcode registers. Captures the ALU result and hands it to the UART transmitter with a one-cycle tx_start, then waits for tx_done_tick before accepting the next command. All handshakes are single-clk pulses in the clk domain.

Parameters:
DBIT, 8, data byte width; matches receiver DBIT.
OPW, 6, opcode width; taken from the low OPW bits of the third byte.
TIMEOUT_CYC, 50000000, inter-byte timeout in clk cycles. Used only with UART_IF_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset; 0 = reset.
rx_done_tick  in  1  one-clk pulse from the receiver; rx_data is valid in the same cycle.
rx_data  in  DBIT  received byte (receiver dout).
alu_result  in  DBIT  combinational ALU output computed from a_out/b_out/op_out.
tx_done_tick  in  1  one-clk pulse from the transmitter at the end of its stop bit.
a_out  out  DBIT  operand A register.
b_out  out  DBIT  operand B register.
op_out  out  OPW  opcode register.
tx_start  out  1  one-clk pulse; tx_data is valid in the same cycle.
tx_data  out  DBIT  result byte held for the transmitter.
busy  out  1  high from the EXEC state through the WAIT_TX state.
overrun  out  1  one-clk pulse when an rx_done_tick is dropped.
frame_err  out  1  one-clk pulse on inter-byte timeout. Tied to 0 without UART_IF_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=GET_A. a_out, b_out, op_out, tx_data = 0. tx_start, busy, overrun, frame_err = 0. Timeout counter = 0.
- The FSM is one-hot over 6 states: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- GET_A: on rx_done_tick, a_out<=rx_data and go to GET_B.
- GET_B: on rx_done_tick, b_out<=rx_data and go to GET_OP.
- GET_OP: on rx_done_tick, op_out<=rx_data[OPW-1:0] and go to EXEC. The upper bits of the byte are ignored.
- EXEC: unconditional single cycle to let the ALU settle, then go to SEND.
- SEND: tx_data<=alu_result, tx_start=1 for this cycle only, then go to WAIT_TX.
- WAIT_TX: on tx_done_tick, go to GET_A. Otherwise stay; there is no timeout in this state.
- Latency: tx_start is asserted exactly 2 clks after the clk in which the opcode's rx_done_tick is sampled.
- Idle ticks: tx_done_tick outside WAIT_TX is ignored.
- Dropped bytes: rx_done_tick in EXEC, SEND or WAIT_TX is dropped, and overrun=1 in that same cycle (registered, visible the next clk). All registers are unchanged.
- Register stability: a_out, b_out and op_out hold their values until overwritten by the next command; they are not cleared between commands. tx_data holds until the next SEND.
- busy is registered and equals 1 while the state is EXEC, SEND or WAIT_TX.
- Reset mid-command: any partial command is discarded and the FSM returns to GET_A. A transmitter already started is not aborted by this block.
- Simultaneous rx_done_tick and tx_done_tick in WAIT_TX: the FSM goes to GET_A, the rx byte is dropped and overrun pulses.

Optional Feature:
Macro: UART_IF_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT_CYC+1) clears on every accepted byte and on entry to GET_A.
  - It increments each clk while in GET_B or GET_OP.
  - When it reaches TIMEOUT_CYC-1 with no rx_done_tick, the FSM goes to GET_A and frame_err pulses for 1 clk.
  - a_out, b_out and op_out are unchanged by a timeout.
  - An rx_done_tick in the same cycle as the timeout wins: the byte is accepted and no frame_err is raised.
- Undefined: no counter; GET_B and GET_OP wait indefinitely; frame_err is constant 0.

Test Plan:
- Basic command: bytes 0x05, 0x03, 0x20 with alu_result driven as a_out+b_out -> a_out=0x05, b_out=0x03, op_out=0x20. tx_start pulses once with tx_data=0x08, 2 clks after the third tick. busy=1 until tx_done_tick.
- Opcode masking: third byte 0xE2 -> op_out=0x22.
- Overrun: rx_done_tick with 0xAA during WAIT_TX -> overrun pulses 1 clk. Registers are unchanged. After tx_done_tick the next command completes normally.
- Async reset: assert reset=0 mid-clock after two bytes, then release, then send 0x01, 0x02, 0x00 -> outputs go to 0 immediately on reset. The new command uses A=0x01, B=0x02, not the stale bytes.
- Back-to-back commands: two commands sent with tx_done_tick returned 10 clks after each tx_start -> exactly two tx_start pulses with the correct tx_data values, and no overrun.
- Timeout (with UART_IF_TIMEOUT_EN, TIMEOUT_CYC=100): send byte 0x11, then idle 100 clks -> frame_err pulses once and the state returns to GET_A. A following 3-byte command completes correctly. Without the macro, the same idle period produces no frame_err.
